// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe: VGA H/V timing generator that presents active-area coordinates to an
// upstream pixel source and delays sync/blank to match that source's read latency, so RGB,
// sync and blank leave the block aligned.
// Optional colour-bar test pattern: define VGA_TEST_PATTERN_EN to add iPattern_Sel.
module vga_timing_pipe #(
   parameter int unsigned H_SYNC        = 96,
   parameter int unsigned H_BACK        = 48,
   parameter int unsigned H_ACT         = 640,
   parameter int unsigned H_FRONT       = 16,
   parameter int unsigned V_SYNC        = 2,
   parameter int unsigned V_BACK        = 33,
   parameter int unsigned V_ACT         = 480,
   parameter int unsigned V_FRONT       = 10,
   parameter int unsigned COLOR_W       = 10,
   parameter int unsigned CNT_W         = 10,
   parameter int unsigned PIXEL_LATENCY = 1,
   parameter int unsigned SYNC_POL      = 0
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic [COLOR_W-1:0] iRed,
   input  logic [COLOR_W-1:0] iGreen,
   input  logic [COLOR_W-1:0] iBlue,
`ifdef VGA_TEST_PATTERN_EN
   input  logic               iPattern_Sel,
`endif
   output logic [CNT_W-1:0]   oCoord_X,
   output logic [CNT_W-1:0]   oCoord_Y,
   output logic               oCoord_Valid,
   output logic               oLine_Start,
   output logic               oFrame_Start,
   output logic [COLOR_W-1:0] oVGA_R,
   output logic [COLOR_W-1:0] oVGA_G,
   output logic [COLOR_W-1:0] oVGA_B,
   output logic               oVGA_H_SYNC,
   output logic               oVGA_V_SYNC,
   output logic               oVGA_BLANK,
   output logic               oVGA_SYNC,
   output logic               oVGA_CLOCK
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
   localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] X_START  = CNT_W'(H_SYNC + H_BACK);
   localparam logic [CNT_W-1:0] X_END    = CNT_W'(H_SYNC + H_BACK + H_ACT);
   localparam logic [CNT_W-1:0] Y_START  = CNT_W'(V_SYNC + V_BACK);
   localparam logic [CNT_W-1:0] Y_END    = CNT_W'(V_SYNC + V_BACK + V_ACT);

   // Asserted sync level; syncs idle at the opposite level.
   localparam logic POL = (SYNC_POL != 0);

`ifdef VGA_TEST_PATTERN_EN
   localparam int unsigned BAR_W = H_ACT / 8;
   localparam int unsigned DW    = 6;  // {bar[2:0], act, vs, hs}
`else
   localparam int unsigned DW    = 3;  // {act, vs, hs}
`endif

   logic [CNT_W-1:0]   r_h_cont;
   logic [CNT_W-1:0]   r_v_cont;
   logic               w_hs_raw;
   logic               w_vs_raw;
   logic               w_act_raw;
   logic [DW-1:0]      w_raw_vec;
   logic [DW-1:0]      w_dly_vec;
   logic               w_dly_hs;
   logic               w_dly_vs;
   logic               w_dly_act;
   logic [COLOR_W-1:0] w_r_next;
   logic [COLOR_W-1:0] w_g_next;
   logic [COLOR_W-1:0] w_b_next;
   logic [COLOR_W-1:0] r_red;
   logic [COLOR_W-1:0] r_green;
   logic [COLOR_W-1:0] r_blue;
   logic               r_hsync;
   logic               r_vsync;
   logic               r_blank;

   // Free-running H/V counters; V advances on the H wrap edge.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_h_cont <= '0;
         r_v_cont <= '0;
      end else if (r_h_cont == H_LAST) begin
         r_h_cont <= '0;
         if (r_v_cont == V_LAST) begin
            r_v_cont <= '0;
         end else begin
            r_v_cont <= r_v_cont + 1'b1;
         end
      end else begin
         r_h_cont <= r_h_cont + 1'b1;
      end
   end

   assign w_hs_raw  = (r_h_cont < H_SYNC_C);
   assign w_vs_raw  = (r_v_cont < V_SYNC_C);
   assign w_act_raw = (r_h_cont >= X_START) && (r_h_cont < X_END) &&
                      (r_v_cont >= Y_START) && (r_v_cont < Y_END);

   assign oCoord_Valid = w_act_raw;
   assign oCoord_X     = w_act_raw ? (r_h_cont - X_START) : '0;
   assign oCoord_Y     = w_act_raw ? (r_v_cont - Y_START) : '0;
   assign oLine_Start  = (r_h_cont == '0);
   assign oFrame_Start = (r_h_cont == '0) && (r_v_cont == '0);

`ifdef VGA_TEST_PATTERN_EN
   logic [2:0] w_bar;

   // Colour-bar index from the active X coordinate, by threshold comparison.
   always_comb begin
      w_bar = '0;
      for (int i = 1; i < 8; i++) begin
         if (oCoord_X >= CNT_W'(i * BAR_W)) begin
            w_bar = 3'(i);
         end
      end
   end

   assign w_raw_vec = {w_bar, w_act_raw, w_vs_raw, w_hs_raw};
`else
   assign w_raw_vec = {w_act_raw, w_vs_raw, w_hs_raw};
`endif

   // Flag delay line matching the pixel source's read latency.
   generate
      if (PIXEL_LATENCY == 0) begin : g_no_dly
         assign w_dly_vec = w_raw_vec;
      end else begin : g_dly
         logic [DW-1:0] r_stage [PIXEL_LATENCY];

         // Shift flags one stage per clock; reset clears every stage to inactive.
         always_ff @(posedge Clock or negedge Resetn) begin
            if (!Resetn) begin
               for (int i = 0; i < int'(PIXEL_LATENCY); i++) begin
                  r_stage[i] <= '0;
               end
            end else begin
               r_stage[0] <= w_raw_vec;
               for (int i = 1; i < int'(PIXEL_LATENCY); i++) begin
                  r_stage[i] <= r_stage[i-1];
               end
            end
         end

         assign w_dly_vec = r_stage[PIXEL_LATENCY-1];
      end
   endgenerate

   assign w_dly_hs  = w_dly_vec[0];
   assign w_dly_vs  = w_dly_vec[1];
   assign w_dly_act = w_dly_vec[2];

   // Next colour: pixel data (or test bars) inside the delayed active window, else black.
   always_comb begin
      w_r_next = '0;
      w_g_next = '0;
      w_b_next = '0;
      if (w_dly_act) begin
`ifdef VGA_TEST_PATTERN_EN
         if (iPattern_Sel) begin
            // Bars: white, yellow, cyan, green, magenta, red, blue, black.
            w_r_next = {COLOR_W{~w_dly_vec[4]}};
            w_g_next = {COLOR_W{~w_dly_vec[5]}};
            w_b_next = {COLOR_W{~w_dly_vec[3]}};
         end else begin
            w_r_next = iRed;
            w_g_next = iGreen;
            w_b_next = iBlue;
         end
`else
         w_r_next = iRed;
         w_g_next = iGreen;
         w_b_next = iBlue;
`endif
      end
   end

   // Output register toward the DAC; sync level follows the selected polarity.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_hsync <= ~POL;
         r_vsync <= ~POL;
         r_blank <= 1'b0;
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
      end else begin
         r_hsync <= ~(w_dly_hs ^ POL);
         r_vsync <= ~(w_dly_vs ^ POL);
         r_blank <= w_dly_act;
         r_red   <= w_r_next;
         r_green <= w_g_next;
         r_blue  <= w_b_next;
      end
   end

   assign oVGA_R      = r_red;
   assign oVGA_G      = r_green;
   assign oVGA_B      = r_blue;
   assign oVGA_H_SYNC = r_hsync;
   assign oVGA_V_SYNC = r_vsync;
   assign oVGA_BLANK  = r_blank;
   assign oVGA_SYNC   = 1'b0;
   assign oVGA_CLOCK  = Clock;

endmodule
